// File: rtl/fpnew_classifier_arbiter_if.sv
// rtl/fpnew_classifier_arbiter_if.sv - requester and result bundle for the shared FP classifier
interface fpnew_classifier_arbiter_if #(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned Width    = 32,
   parameter int unsigned TagWidth = 4,
   parameter int unsigned IdWidth  = 2
);
   logic [NumReq-1:0]          req_valid_i;
   logic [NumReq-1:0]          req_ready_o;
   logic [NumReq*Width-1:0]    req_operand_i;
   logic [NumReq-1:0]          req_is_boxed_i;
   logic [NumReq*TagWidth-1:0] req_tag_i;
   logic                       out_valid_o;
   logic                       out_ready_i;
   logic [7:0]                 out_info_o;
   logic [9:0]                 out_class_o;
   logic [TagWidth-1:0]        out_tag_o;
   logic [IdWidth-1:0]         out_id_o;

   modport slave (
      input  req_valid_i, req_operand_i, req_is_boxed_i, req_tag_i, out_ready_i,
      output req_ready_o, out_valid_o, out_info_o, out_class_o, out_tag_o, out_id_o
   );

   modport master (
      output req_valid_i, req_operand_i, req_is_boxed_i, req_tag_i, out_ready_i,
      input  req_ready_o, out_valid_o, out_info_o, out_class_o, out_tag_o, out_id_o
   );
endinterface

// File: rtl/fpnew_classifier_arbiter.sv
// rtl/fpnew_classifier_arbiter.sv - round-robin shared FP classifier, two-stage pipeline
// S1 holds the granted operand, S2 holds the classification result driven on the outputs.
module fpnew_classifier_arbiter #(
   parameter logic [2:0]  FpFormat = 3'd0,
   parameter int unsigned NumReq   = 4,
   parameter int unsigned TagWidth = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   fpnew_classifier_arbiter_if.slave     bus,
   output logic                          busy_o
);
   localparam int unsigned IdWidth = $clog2(NumReq);
   localparam int unsigned Width   = (FpFormat == 3'd1) ? 64 :
                                     (FpFormat == 3'd2 || FpFormat == 3'd4) ? 16 :
                                     (FpFormat == 3'd3) ? 8 : 32;
   localparam int unsigned ExpBits = (FpFormat == 3'd1) ? 11 :
                                     (FpFormat == 3'd2 || FpFormat == 3'd3) ? 5 : 8;
   localparam int unsigned ManBits = Width - 1 - ExpBits;

   logic [IdWidth-1:0]  rr_ptr_q, rr_ptr_d;
   logic                s1_valid_q, s1_valid_d;
   logic [Width-1:0]    s1_op_q, s1_op_d;
   logic                s1_boxed_q, s1_boxed_d;
   logic [TagWidth-1:0] s1_tag_q, s1_tag_d;
   logic [IdWidth-1:0]  s1_id_q, s1_id_d;
   logic                s2_valid_q, s2_valid_d;
   logic [7:0]          s2_info_q, s2_info_d;
   logic [9:0]          s2_class_q, s2_class_d;
   logic [TagWidth-1:0] s2_tag_q, s2_tag_d;
   logic [IdWidth-1:0]  s2_id_q, s2_id_d;

   logic                grant_found;
   logic [IdWidth-1:0]  grant_idx;
   logic [IdWidth:0]    scan_idx;
   logic                s2_load, s1_adv, s1_ready, accept;
   logic                sign_f;
   logic [ExpBits-1:0]  exp_f;
   logic [ManBits-1:0]  man_f;
   logic [7:0]          cls_info;
   logic [9:0]          cls_mask;

   assign s2_load  = !s2_valid_q || bus.out_ready_i;
   assign s1_adv   = s1_valid_q && s2_load;
   assign s1_ready = !s1_valid_q || s1_adv;
   assign accept   = grant_found && s1_ready && !flush_i;

   // Search upward from the round-robin pointer, wrapping at NumReq.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < NumReq; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IdWidth+1)'(k);
         if (scan_idx >= (IdWidth+1)'(NumReq)) scan_idx = scan_idx - (IdWidth+1)'(NumReq);
         if (!grant_found && bus.req_valid_i[scan_idx[IdWidth-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[IdWidth-1:0];
         end
      end
   end

   always_comb begin
      bus.req_ready_o = '0;
      if (accept) bus.req_ready_o[grant_idx] = 1'b1;
   end

   assign sign_f = s1_op_q[Width-1];
   assign exp_f  = s1_op_q[Width-2 -: ExpBits];
   assign man_f  = s1_op_q[ManBits-1:0];

   // Info bits: {normal,subnormal,zero,inf,nan,snan,qnan,boxed}; unboxed reads as a quiet NaN.
   always_comb begin
      cls_info = '0;
      cls_mask = '0;
      if (!s1_boxed_q) begin
         cls_info    = 8'b0000_1010;
         cls_mask[9] = 1'b1;
      end else begin
         cls_info[0] = 1'b1;
         if (&exp_f) begin
            if (man_f != '0) begin
               cls_info[3] = 1'b1;
               if (man_f[ManBits-1]) begin
                  cls_info[1] = 1'b1;
                  cls_mask[9] = 1'b1;
               end else begin
                  cls_info[2] = 1'b1;
                  cls_mask[8] = 1'b1;
               end
            end else begin
               cls_info[4] = 1'b1;
               cls_mask[sign_f ? 0 : 7] = 1'b1;
            end
         end else if (exp_f == '0) begin
            if (man_f == '0) begin
               cls_info[5] = 1'b1;
               cls_mask[sign_f ? 3 : 4] = 1'b1;
            end else begin
               cls_info[6] = 1'b1;
               cls_mask[sign_f ? 2 : 5] = 1'b1;
            end
         end else begin
            cls_info[7] = 1'b1;
            cls_mask[sign_f ? 1 : 6] = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_boxed_d = s1_boxed_q;
      s1_tag_d   = s1_tag_q;
      s1_id_d    = s1_id_q;
      s2_valid_d = s2_valid_q;
      s2_info_d  = s2_info_q;
      s2_class_d = s2_class_q;
      s2_tag_d   = s2_tag_q;
      s2_id_d    = s2_id_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = bus.req_operand_i[32'(grant_idx)*Width +: Width];
         s1_boxed_d = bus.req_is_boxed_i[grant_idx];
         s1_tag_d   = bus.req_tag_i[32'(grant_idx)*TagWidth +: TagWidth];
         s1_id_d    = grant_idx;
         rr_ptr_d   = (grant_idx == IdWidth'(NumReq-1)) ? '0 : grant_idx + 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_info_d  = cls_info;
         s2_class_d = cls_mask;
         s2_tag_d   = s1_tag_q;
         s2_id_d    = s1_id_q;
      end else if (bus.out_ready_i) begin
         s2_valid_d = 1'b0;
      end
      // Flush wins over any drain or advance in the same cycle; the pointer is kept.
      if (flush_i) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_boxed_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_info_q  <= '0;
         s2_class_q <= '0;
         s2_tag_q   <= '0;
         s2_id_q    <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_boxed_q <= s1_boxed_d;
         s1_tag_q   <= s1_tag_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s2_valid_d;
         s2_info_q  <= s2_info_d;
         s2_class_q <= s2_class_d;
         s2_tag_q   <= s2_tag_d;
         s2_id_q    <= s2_id_d;
      end
   end

   assign bus.out_valid_o = s2_valid_q;
   assign bus.out_info_o  = s2_info_q;
   assign bus.out_class_o = s2_class_q;
   assign bus.out_tag_o   = s2_tag_q;
   assign bus.out_id_o    = s2_id_q;
   assign busy_o          = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_fpnew_classifier_arbiter.sv
// tb/tb_fpnew_classifier_arbiter.sv - random and directed checks against an in-order queue model
module tb_fpnew_classifier_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TW = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic busy;

   fpnew_classifier_arbiter_if #(.NumReq(N), .Width(W), .TagWidth(TW), .IdWidth(IW)) bus();

   fpnew_classifier_arbiter #(.FpFormat(3'd0), .NumReq(N), .TagWidth(TW)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(flush),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]    info;
      logic [9:0]    cls;
      logic [TW-1:0] tag;
      logic [IW-1:0] id;
      int            stage;
   } ent_t;

   ent_t          pipe[$];
   int            rr;
   int            total;
   int            bad;
   int            hs_cnt;
   logic [W-1:0]  ops [N];
   logic [N-1:0]  boxed;
   logic [TW-1:0] tags [N];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic ent_t ref_class(input logic [W-1:0] op, input logic bx);
      ent_t        e;
      int          k;
      logic        s;
      int          ex;
      int unsigned mn;
      s  = op[31];
      ex = int'(op[30:23]);
      mn = 32'(op[22:0]);
      e.tag = '0;
      e.id = '0;
      e.stage = 0;
      if (!bx) begin k = 9; e.info = 8'h0A; end
      else if (ex == 255 && mn != 0) begin
         k = (mn >= (1 << 22)) ? 9 : 8;
         e.info = (k == 9) ? 8'h0B : 8'h0D;
      end
      else if (ex == 255)           begin k = s ? 0 : 7; e.info = 8'h11; end
      else if (ex == 0 && mn == 0)  begin k = s ? 3 : 4; e.info = 8'h21; end
      else if (ex == 0)             begin k = s ? 2 : 5; e.info = 8'h41; end
      else                          begin k = s ? 1 : 6; e.info = 8'h81; end
      e.cls = 10'(1) << k;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [7:0]  ex;
      logic [22:0] mn;
      case ($urandom_range(0, 3))
         0:       ex = 8'h00;
         1:       ex = 8'hFF;
         default: ex = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0:       mn = '0;
         1:       mn = 23'h400000;
         2:       mn = 23'h000001;
         default: mn = 23'($urandom);
      endcase
      return {1'($urandom), ex, mn};
   endfunction

   task automatic step(input logic [N-1:0] v, input logic ordy, input logic fl);
      int           g;
      int           idx;
      logic         s1f, s2f, moves, acc;
      logic [N-1:0] exp_rdy;
      ent_t         e;
      @(negedge clk);
      bus.req_valid_i    = v;
      bus.out_ready_i    = ordy;
      bus.req_is_boxed_i = boxed;
      flush = fl;
      for (int i = 0; i < N; i++) begin
         bus.req_operand_i[i*W +: W]   = ops[i];
         bus.req_tag_i[i*TW +: TW]     = tags[i];
      end
      #1;
      s2f = pipe.size() > 0 && pipe[0].stage == 2;
      s1f = pipe.size() > 0 && pipe[pipe.size()-1].stage == 1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (rr + k) % N;
         if (g < 0 && v[idx]) g = idx;
      end
      moves = s1f && (!s2f || ordy);
      acc = (g >= 0) && (!s1f || moves) && !fl;
      exp_rdy = acc ? (N'(1) << g) : '0;
      chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      chk("out_valid", 64'(bus.out_valid_o), 64'(s2f));
      if (s2f) begin
         chk("out_info", 64'(bus.out_info_o), 64'(pipe[0].info));
         chk("out_class", 64'(bus.out_class_o), 64'(pipe[0].cls));
         chk("out_tag", 64'(bus.out_tag_o), 64'(pipe[0].tag));
         chk("out_id", 64'(bus.out_id_o), 64'(pipe[0].id));
      end
      chk("busy", 64'(busy), 64'(pipe.size() != 0));
      if ((v & bus.req_ready_o) != '0) hs_cnt++;
      if (fl) pipe.delete();
      else begin
         if (s2f && ordy) void'(pipe.pop_front());
         if (moves) pipe[pipe.size()-1].stage = 2;
         if (acc) begin
            e = ref_class(ops[g], boxed[g]);
            e.tag = tags[g];
            e.id = IW'(g);
            e.stage = 1;
            pipe.push_back(e);
            rr = (g + 1) % N;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid_i = '0;
      bus.out_ready_i = 1'b0;
      flush = 1'b0;
      pipe.delete();
      rr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.out_valid_o), 64'(0));
      chk("rst_info", 64'(bus.out_info_o), 64'(0));
      chk("rst_class", 64'(bus.out_class_o), 64'(0));
      chk("rst_tag", 64'(bus.out_tag_o), 64'(0));
      chk("rst_id", 64'(bus.out_id_o), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
   endtask

   logic [W-1:0] t2_ops [5] = '{32'hFF800000, 32'h80000001, 32'h7F800001, 32'h00000000, 32'h3F800000};
   logic [9:0]   t2_cls [5] = '{10'h001, 10'h004, 10'h100, 10'h010, 10'h200};
   int           rr_before;

   initial begin
      total = 0;
      bad = 0;
      rr = 0;
      hs_cnt = 0;
      boxed = '1;
      for (int i = 0; i < N; i++) begin
         ops[i] = '0;
         tags[i] = TW'(i);
      end
      bus.req_valid_i    = '0;
      bus.req_operand_i  = '0;
      bus.req_is_boxed_i = '1;
      bus.req_tag_i      = '0;
      bus.out_ready_i    = 1'b0;
      do_reset();

      ops[0] = 32'h3F800000;
      tags[0] = 4'h5;
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      chk("t1_info", 64'(bus.out_info_o), 64'(8'h81));
      chk("t1_class", 64'(bus.out_class_o), 64'(10'h040));
      chk("t1_id", 64'(bus.out_id_o), 64'(0));

      for (int t = 0; t < 5; t++) begin
         ops[1] = t2_ops[t];
         boxed[1] = (t != 4);
         step(4'b0010, 1'b1, 1'b0);
         step(4'b0000, 1'b1, 1'b0);
         step(4'b0000, 1'b1, 1'b0);
         chk("t2_class", 64'(bus.out_class_o), 64'(t2_cls[t]));
         if (t == 4) chk("t3_info", 64'(bus.out_info_o), 64'(8'h0A));
      end
      boxed = '1;

      do_reset();
      for (int i = 0; i < N; i++) ops[i] = rand_op();
      for (int i = 0; i < 10; i++) begin
         step(4'hF, 1'b1, 1'b0);
         if (i >= 2) begin
            chk("t4_valid", 64'(bus.out_valid_o), 64'(1));
            chk("t4_id", 64'(bus.out_id_o), 64'((i - 2) % 4));
         end
      end
      repeat (3) step(4'h0, 1'b1, 1'b0);

      hs_cnt = 0;
      repeat (3) step(4'hF, 1'b0, 1'b0);
      chk("t5_accepted", 64'(hs_cnt), 64'(2));
      chk("t5_ready", 64'(bus.req_ready_o), 64'(0));
      repeat (4) step(4'h0, 1'b1, 1'b0);

      step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);
      rr_before = rr;
      step(4'hF, 1'b1, 1'b1);
      chk("t6_flush_ready", 64'(bus.req_ready_o), 64'(0));
      step(4'h0, 1'b1, 1'b0);
      chk("t6_valid", 64'(bus.out_valid_o), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      step(4'hF, 1'b1, 1'b0);
      chk("t6_grant", 64'(bus.req_ready_o), 64'(4'b0001 << rr_before));

      step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b0);
      do_reset();
      step(4'hF, 1'b1, 1'b0);
      chk("rst_mid_grant", 64'(bus.req_ready_o), 64'(4'b0001));

      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            ops[i] = rand_op();
            tags[i] = TW'($urandom);
         end
         boxed = N'($urandom) | N'($urandom);
         step(N'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
      repeat (4) step(4'h0, 1'b1, 1'b0);
      chk("final_busy", 64'(busy), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
